mux_n_pipe: RTL



---
 rtl/mux_n_pipe_pkg.sv | 8 +
 rtl/mux_n_sel.sv | 19 +
 rtl/mux_n_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/mux_n_pipe_pkg.sv
// mux_n_pipe_pkg: shared state encoding, beat layout width and error-counter width
package mux_n_pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  localparam int ERR_CNT_W = 8;
  function automatic int beat_w(input int width, input int sel_w);
    return width + sel_w + 1;
  endfunction
endpackage

// File: rtl/mux_n_sel.sv
// mux_n_sel: combinational N-way channel select, DEFAULT_VAL and err for out-of-range selects
module mux_n_sel #(
  parameter int N_IN = 3,
  parameter int WIDTH = 16,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic [N_IN*WIDTH-1:0] chans,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data,
  output logic                  err
);
  always_comb begin
    data = DEFAULT_VAL;
    for (int k = 0; k < N_IN; k++)
      if (sel == SEL_W'(k)) data = chans[k*WIDTH +: WIDTH];
  end
  assign err = 32'(sel) >= N_IN;
endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input selector with valid/ready output stage and 2-entry skid buffer.
// Optional MUX_N_PIPE_ERR_CNT_EN adds a saturating out-of-range beat counter (err_cnt).
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int WIDTH = 16,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  err_clr,
  output logic                  sel_err
`ifdef MUX_N_PIPE_ERR_CNT_EN
  ,output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
  localparam int BW = beat_w(WIDTH, SEL_W);
  state_t state, nxt;
  logic [BW-1:0] main_q, skid_q, beat;
  logic [WIDTH-1:0] sel_data;
  logic sel_oor, acc, ld_new, ld_skid, ld_from_skid;
  mux_n_sel #(.N_IN(N_IN), .WIDTH(WIDTH), .SEL_W(SEL_W), .DEFAULT_VAL(DEFAULT_VAL)) u_sel (
    .chans(in_data),
    .sel(in_sel),
    .data(sel_data),
    .err(sel_oor)
  );
  assign beat = {sel_data, in_sel, sel_oor};
  assign acc = in_valid & in_ready;
  assign {out_data, out_chan, out_err} = main_q;
  // in_ready depends on state only, so out_ready never reaches it combinationally
  always_comb begin
    nxt = state;
    in_ready = 1'b1;
    out_valid = 1'b1;
    ld_new = 1'b0;
    ld_skid = 1'b0;
    ld_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        out_valid = 1'b0;
        ld_new = in_valid;
        nxt = in_valid ? ONE : EMPTY;
      end
      ONE: begin
        ld_new = in_valid & out_ready;
        ld_skid = in_valid & ~out_ready;
        nxt = (in_valid & ~out_ready) ? FULL : (~in_valid & out_ready) ? EMPTY : ONE;
      end
      FULL: begin
        in_ready = 1'b0;
        ld_from_skid = out_ready;
        nxt = out_ready ? ONE : FULL;
      end
      default: begin
        out_valid = 1'b0;
        nxt = EMPTY;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= EMPTY;
    else state <= nxt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
      sel_err <= 1'b0;
    end else begin
      if (ld_new) main_q <= beat;
      else if (ld_from_skid) main_q <= skid_q;
      if (ld_skid) skid_q <= beat;
      sel_err <= (acc & sel_oor) | (sel_err & ~err_clr);
    end
  end
`ifdef MUX_N_PIPE_ERR_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_cnt <= '0;
    else if (err_clr) err_cnt <= '0;
    else if (acc & sel_oor & ~&err_cnt) err_cnt <= err_cnt + 1'b1;
  end
`endif
endmodule
